// File: rtl/mouse_player_cond_if.sv
// Player-side mouse bus: raw mouse/enable/tick inputs towards the conditioner
// and the conditioned position/button outputs back to the game logic.
interface mouse_player_cond_if #(
  parameter int WIDTH = 12
);
  logic             enable;
  logic [WIDTH-1:0] xpos_in;
  logic [WIDTH-1:0] ypos_in;
  logic             left_in;
  logic             frame_tick;
  logic [WIDTH-1:0] xpos_out;
  logic [WIDTH-1:0] ypos_out;
  logic             click_out;
  logic             jump_pulse;

  modport master (
    output enable, xpos_in, ypos_in, left_in, frame_tick,
    input  xpos_out, ypos_out, click_out, jump_pulse
  );

  modport slave (
    input  enable, xpos_in, ypos_in, left_in, frame_tick,
    output xpos_out, ypos_out, click_out, jump_pulse
  );
endinterface

// File: rtl/mouse_player_cond.sv
// Mouse-to-player conditioner: delay pipeline, clamp, per-frame position update and
// button press qualification. Define MOUSE_SLEW_LIMIT_EN to limit movement to MAX_STEP per frame.
module mouse_player_cond #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 3,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 1023,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 767,
  parameter int DEF_X       = 50,
  parameter int DEF_Y       = 679,
  parameter int MAX_STEP    = 16
) (
  input logic                clk,
  input logic                rst,
  mouse_player_cond_if.slave bus
);

  typedef enum logic [1:0] {
    DISABLED,
    IDLE,
    HOLD,
    WAIT_REL
  } state_t;

  localparam logic [WIDTH-1:0] X_LO  = X_MIN[WIDTH-1:0];
  localparam logic [WIDTH-1:0] X_HI  = X_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] Y_LO  = Y_MIN[WIDTH-1:0];
  localparam logic [WIDTH-1:0] Y_HI  = Y_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DEF_XV = DEF_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DEF_YV = DEF_Y[WIDTH-1:0];

  logic [WIDTH-1:0] x_pipe [SYNC_STAGES];
  logic [WIDTH-1:0] y_pipe [SYNC_STAGES];
  logic             left_pipe [SYNC_STAGES];
  logic [WIDTH-1:0] tgt_x;
  logic [WIDTH-1:0] tgt_y;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] next_x;
  logic [WIDTH-1:0] next_y;
  logic             d_left;
  logic             click_q;
  logic             jump_q;
  logic             pulse_d;
  state_t           state_q;
  state_t           state_d;

  function automatic logic [WIDTH-1:0] clamp_val(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // The raw mouse values come from another domain, so every field rides the same delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        x_pipe[i]    <= '0;
        y_pipe[i]    <= '0;
        left_pipe[i] <= 1'b0;
      end
    end else begin
      x_pipe[0]    <= bus.xpos_in;
      y_pipe[0]    <= bus.ypos_in;
      left_pipe[0] <= bus.left_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        x_pipe[i]    <= x_pipe[i-1];
        y_pipe[i]    <= y_pipe[i-1];
        left_pipe[i] <= left_pipe[i-1];
      end
    end
  end

  assign d_left = left_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_x <= '0;
      tgt_y <= '0;
    end else begin
      tgt_x <= clamp_val(x_pipe[SYNC_STAGES-1], X_LO, X_HI);
      tgt_y <= clamp_val(y_pipe[SYNC_STAGES-1], Y_LO, Y_HI);
    end
  end

`ifdef MOUSE_SLEW_LIMIT_EN
  localparam logic signed [WIDTH:0] STEP_S = MAX_STEP[WIDTH:0];
  localparam logic [WIDTH-1:0]      STEP_U = MAX_STEP[WIDTH-1:0];

  // Both operands lie inside the clamp window, so stepping toward the target cannot leave it.
  function automatic logic [WIDTH-1:0] slew_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    logic signed [WIDTH:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S) return cur + STEP_U;
    if (diff < -STEP_S) return cur - STEP_U;
    return tgt;
  endfunction

  assign next_x = slew_step(x_q, tgt_x);
  assign next_y = slew_step(y_q, tgt_y);
`else
  assign next_x = tgt_x;
  assign next_y = tgt_y;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= DEF_XV;
      y_q <= DEF_YV;
    end else if (!bus.enable) begin
      x_q <= DEF_XV;
      y_q <= DEF_YV;
    end else if (bus.frame_tick) begin
      x_q <= next_x;
      y_q <= next_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DISABLED;
      click_q <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      click_q <= (state_d == HOLD);
      jump_q  <= pulse_d;
    end
  end

  // A button already down when control is granted must be released before it can count.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    if (!bus.enable) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = d_left ? WAIT_REL : IDLE;
        IDLE: begin
          if (d_left) begin
            state_d = HOLD;
            pulse_d = 1'b1;
          end
        end
        HOLD:     if (!d_left) state_d = IDLE;
        WAIT_REL: if (!d_left) state_d = IDLE;
        default:  state_d = DISABLED;
      endcase
    end
  end

  assign bus.xpos_out   = x_q;
  assign bus.ypos_out   = y_q;
  assign bus.click_out  = click_q;
  assign bus.jump_pulse = jump_q;

endmodule

// File: doc/mouse_player_cond.md
MOUSE_PLAYER_COND -- requirements
Module: mouse_player_cond

Interface
REQ-001 Parameter WIDTH, 12, coordinate width in bits.
REQ-002 Parameter SYNC_STAGES, 3, input delay-pipeline depth (>=1).
REQ-003 Parameter X_MIN, 0 / X_MAX, 1023, player horizontal clamp bounds (X_MIN<=X_MAX).
REQ-004 Parameter Y_MIN, 0 / Y_MAX, 767, player vertical clamp bounds (Y_MIN<=Y_MAX).
REQ-005 Parameter DEF_X, 50 / DEF_Y, 679, parked position when disabled or after reset.
REQ-006 Parameter MAX_STEP, 16, max per-axis movement per frame tick (1..2^WIDTH-1).
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 enable  in  1  mouse control enabled for this player.
REQ-010 xpos_in / ypos_in  in  WIDTH  raw mouse position from mouse controller domain.
REQ-011 left_in  in  1  raw left-button level.
REQ-012 frame_tick  in  1  one-cycle pulse per video frame.
REQ-013 xpos_out / ypos_out  out  WIDTH  conditioned player position (registered).
REQ-014 click_out  out  1  qualified button level (registered).
REQ-015 jump_pulse  out  1  one-cycle pulse per qualified press.

Function
REQ-016 {left_in,xpos_in,ypos_in} SHALL pass through SYNC_STAGES register stages; clamp stage adds 1 cycle (target valid SYNC_STAGES+1 cycles after input).
REQ-017 Target SHALL be delayed x/y clamped unsigned to [X_MIN,X_MAX] / [Y_MIN,Y_MAX].
REQ-018 Outputs SHALL change only on frame_tick while enabled; between ticks they hold.
REQ-019 Slew: per axis, diff computed in WIDTH+1 signed bits; |diff|<=MAX_STEP -> out=target, else out moves MAX_STEP toward target; never overshoots, never leaves clamp range.
REQ-020 Button FSM states DISABLED, IDLE, HOLD, WAIT_REL.
REQ-021 DISABLED -> (enable=1) WAIT_REL if delayed left=1, else IDLE.
REQ-022 IDLE -> HOLD on delayed left=1; jump_pulse=1 on exactly that transition cycle.
REQ-023 HOLD -> IDLE on delayed left=0; WAIT_REL -> IDLE on delayed left=0 (no pulse).
REQ-024 Any state -> DISABLED when enable=0; enable=0 has priority over frame_tick and button events in same cycle.
REQ-025 click_out=1 only in HOLD; 0 otherwise.
REQ-026 In DISABLED, xpos_out/ypos_out SHALL be DEF_X/DEF_Y from the cycle after enable falls; on re-enable slewing starts from DEF.
REQ-027 Button held across enable rise SHALL NOT produce jump_pulse until released and re-pressed.

Reset
REQ-028 rst=1 SHALL on next edge set xpos_out=DEF_X, ypos_out=DEF_Y, click_out=0, jump_pulse=0, FSM=DISABLED, all pipeline stages=0; rst mid-slew or mid-HOLD aborts immediately.
REQ-029 rst SHALL override enable, frame_tick and all inputs.

Configuration
REQ-030 Macro MOUSE_SLEW_LIMIT_EN defined: slew limiter per REQ-019.
REQ-031 Macro undefined: on frame_tick outputs load clamped target directly (no step limit); all else unchanged.

Verification
REQ-032 Slew on, enable=1, xpos_in=2000 held: after 3 frame_ticks xpos_out=66,82,98 (clamped target 1023).
REQ-033 Slew on, out=50, xpos_in=55: single frame_tick -> xpos_out=55, no overshoot.
REQ-034 left_in high 10 cycles: jump_pulse high exactly 1 cycle, 4 cycles after rise (SYNC_STAGES=3); click_out high 10 cycles.
REQ-035 enable falls during HOLD: next cycle xpos_out=50, ypos_out=679, click_out=0; re-enable with left held -> no pulse until release and new press.
REQ-036 rst pulsed mid-slew (out=82): next cycle out=50/679, jump_pulse=0, FSM DISABLED.
REQ-037 Slew off: xpos_in=1000, one frame_tick after pipeline fill -> xpos_out=1000.
